cmult_cfg: RTL
==============

Name: cmult_cfg

Overview:
Parametrised, fully pipelined complex multiplier for the OFDM receiver chain (FFT twiddle stage, channel equaliser, phase de-rotation). Computes p = a'·b', where a' and b' are a and b after a per-sample conjugate/negate mode. Uses the 3-multiplier shared-term structure, with round-half-up and saturation to a configurable output width. It adds a valid/ready handshake with full backpressure, replacing the fixed enable-delay chains.

Parameters:
A_W, 16, signed width of ar/ai (Q-format data)
B_W, 16, signed width of br/bi (twiddle/coefficient)
FRAC, 9, fractional bits removed from the full product (arithmetic right shift)
OUT_W, 16, signed width of pr/pi
ROUND, 1, 1 = round half up before shift; 0 = truncate (floor)
SAT, 1, 1 = saturate to OUT_W; 0 = wrap (keep low OUT_W bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
mode  in  2  per-sample op: 00 a·b, 01 conj(a)·b, 10 a·conj(b), 11 −(conj(a)·b)
ar, ai  in  A_W  operand a (signed)
br, bi  in  B_W  operand b (signed)
out_valid  out  1  pr/pi/ovf valid
out_ready  in  1  downstream accepts output
pr, pi  out  OUT_W  product real/imag (signed)
ovf  out  1  saturation/wrap occurred on pr or pi for this sample

Behaviour:
- Reset (async, rst_n=0): all stage valid bits=0, out_valid=0, pr=pi=0, ovf=0, all data regs=0. Reset mid-stream flushes every in-flight sample; none emerges after release.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv=0, all stages hold data and valid bits. No bubble collapsing is required.
- Latency: 4 cycles. A sample accepted at edge t gives out_valid=1 after edge t+4 if adv held; each stall cycle adds 1. Throughput is 1 sample/cycle.
- S1: register operands, sign-extended by 1 bit (A_W+1, B_W+1) so negating the most-negative value is exact.
  - ai' = −ai if mode∈{01,11}.
  - bi' = −bi if mode=10.
  - mode=11 negates both br' and bi'.
  - Register the valid bit.
- S2: pre-adds at full width: d0 = ar'−ai' (A_W+2), d1 = br'−bi', d2 = br'+bi' (B_W+2). Delay ar', ai', bi' to align.
- S3: products: c = bi'·d0, m_r = ar'·d1, m_i = ai'·d2. Full precision, A_W+B_W+3 bits.
- S4: form full sums, then round, shift, saturate, and register to the outputs.
  - Full sums: Pr = m_r + c, Pi = m_i + c (A_W+B_W+4 bits).
  - If ROUND=1, add 2^(FRAC−1) (no add when FRAC=0).
  - Arithmetic shift right by FRAC.
  - If SAT=1, clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - ovf = 1 if either component was outside that range (under SAT=0 the value wraps and ovf still reports it).
- Identity: Pr = ar'br' − ai'bi', Pi = ai'br' + ar'bi'. Output must be bit-exact against a full-precision reference model.
- Stage data registers may update freely when their valid bit is 0. pr/pi/ovf only change on an adv edge.
- Simultaneous in/out transfer while full: the new sample enters S1 and the pipeline shifts in the same cycle, with no loss or duplication.
- mode is sampled with its operands; per-sample mode changes are legal every cycle.

Test Plan:
1. Defaults, mode=00, a=(512,256), b=(512,512) [1+0.5j]·[1+1j] -> pr=256, pi=768, ovf=0, out_valid 4 cycles after accept.
2. Same operands, mode=01 -> (768,256); mode=10 -> (768,−256); mode=11 -> (−768,−256); back-to-back, in order, one per cycle.
3. Rounding: a=(1,0), b=(256,0), mode=00 -> pr=1 (ROUND=1) / pr=0 (ROUND=0). a=(−1,0), b=(256,0) -> pr=0 (ROUND=1) / pr=−1 (ROUND=0).
4. Saturation: a=(32767,0), b=(32767,0) -> pr=32767, ovf=1. a=(−32768,0), b=(−32768,0) -> pr=32767, ovf=1. a=(−32768,0), b=(512,0), mode=11 -> pr=32767, ovf=1 (negation exact before clamp).
5. Backpressure: stream 8 random samples, out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid=1 and stalled; all 8 outputs match the model, in order, no duplicates.
6. Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0, pr=pi=0 immediately. After release, first output corresponds to the first sample accepted post-reset.

Source files
------------

// File: rtl/cmult_cfg_if.sv
// rtl/cmult_cfg_if.sv - sample-in / product-out handshake bundle for cmult_cfg
interface cmult_cfg_if #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              mode;
    logic signed [A_W-1:0]   ar;
    logic signed [A_W-1:0]   ai;
    logic signed [B_W-1:0]   br;
    logic signed [B_W-1:0]   bi;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] pr;
    logic signed [OUT_W-1:0] pi;
    logic                    ovf;

    modport master (
        output in_valid, mode, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, pr, pi, ovf
    );

    modport slave (
        input  in_valid, mode, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, pr, pi, ovf
    );
endinterface

// File: rtl/cmult_cfg.sv
// rtl/cmult_cfg.sv - pipelined 3-multiplier complex multiply with mode, round and saturate
module cmult_cfg #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int FRAC  = 9,
    parameter int OUT_W = 16,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    cmult_cfg_if.slave bus
);
    localparam int AW1 = A_W + 1;
    localparam int BW1 = B_W + 1;
    localparam int AW2 = A_W + 2;
    localparam int BW2 = B_W + 2;
    localparam int PW  = A_W + B_W + 3;
    localparam int SW  = A_W + B_W + 4;
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [SW-1:0] RND  = (ROUND != 0 && FRAC > 0) ? (SW'(1) << RSH) : '0;
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;
    localparam logic [OUT_W-1:0]     OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     OMIN = ~OMAX;

    logic adv;

    // S1: operands widened by one bit so negating the most-negative value is exact
    logic signed [AW1-1:0] ar_x, ai_x, ai_m;
    logic signed [BW1-1:0] br_x, bi_x, br_m, bi_m;
    logic                  v1;
    logic signed [AW1-1:0] ar1, ai1;
    logic signed [BW1-1:0] br1, bi1;

    // S2: pre-adds plus aligned operand copies
    logic                  v2;
    logic signed [AW2-1:0] d0_2;
    logic signed [BW2-1:0] d1_2, d2_2;
    logic signed [AW1-1:0] ar2, ai2;
    logic signed [BW1-1:0] bi2;

    // S3: the three products
    logic                  v3;
    logic signed [PW-1:0]  c3, mr3, mi3;

    // S4: full-precision sums, then round/shift/saturate into the output register
    logic                  v4;
    logic signed [SW-1:0]  sr4, si4;
    logic [OUT_W:0]        res_r, res_i;

    logic                  ov_q;
    logic [OUT_W-1:0]      pr_q, pi_q;
    logic                  ovf_q;

    assign adv           = !ov_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = ov_q;
    assign bus.pr        = pr_q;
    assign bus.pi        = pi_q;
    assign bus.ovf       = ovf_q;

    // Returns {overflow, OUT_W-bit result}; overflow is reported even when wrapping
    function automatic logic [OUT_W:0] scale(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        logic                 o;
        t = (s + RND) >>> FRAC;
        o = (t > MAXV) || (t < MINV);
        if (SAT != 0 && o)
            scale = {1'b1, (t[SW-1] ? OMIN : OMAX)};
        else
            scale = {o, t[OUT_W-1:0]};
    endfunction

    always_comb begin
        ar_x  = {bus.ar[A_W-1], bus.ar};
        ai_x  = {bus.ai[A_W-1], bus.ai};
        br_x  = {bus.br[B_W-1], bus.br};
        bi_x  = {bus.bi[B_W-1], bus.bi};
        ai_m  = bus.mode[0] ? -ai_x : ai_x;
        br_m  = (bus.mode == 2'b11) ? -br_x : br_x;
        bi_m  = bus.mode[1] ? -bi_x : bi_x;
        res_r = scale(sr4);
        res_i = scale(si4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            ar1   <= '0;
            ai1   <= '0;
            br1   <= '0;
            bi1   <= '0;
            v2    <= 1'b0;
            d0_2  <= '0;
            d1_2  <= '0;
            d2_2  <= '0;
            ar2   <= '0;
            ai2   <= '0;
            bi2   <= '0;
            v3    <= 1'b0;
            c3    <= '0;
            mr3   <= '0;
            mi3   <= '0;
            v4    <= 1'b0;
            sr4   <= '0;
            si4   <= '0;
            ov_q  <= 1'b0;
            pr_q  <= '0;
            pi_q  <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v1    <= bus.in_valid;
            ar1   <= ar_x;
            ai1   <= ai_m;
            br1   <= br_m;
            bi1   <= bi_m;

            v2    <= v1;
            d0_2  <= {ar1[AW1-1], ar1} - {ai1[AW1-1], ai1};
            d1_2  <= {br1[BW1-1], br1} - {bi1[BW1-1], bi1};
            d2_2  <= {br1[BW1-1], br1} + {bi1[BW1-1], bi1};
            ar2   <= ar1;
            ai2   <= ai1;
            bi2   <= bi1;

            v3    <= v2;
            c3    <= PW'(bi2) * PW'(d0_2);
            mr3   <= PW'(ar2) * PW'(d1_2);
            mi3   <= PW'(ai2) * PW'(d2_2);

            v4    <= v3;
            sr4   <= SW'(mr3) + SW'(c3);
            si4   <= SW'(mi3) + SW'(c3);

            ov_q  <= v4;
            pr_q  <= res_r[OUT_W-1:0];
            pi_q  <= res_i[OUT_W-1:0];
            ovf_q <= res_r[OUT_W] | res_i[OUT_W];
        end
    end
endmodule
